// File: rtl/md_hilo_unit.sv
// rtl/md_hilo_unit.sv - E-stage multiply/divide unit with HI/LO registers
//
// Purpose: accepts mult/multu/div/divu (and madd/maddu when MD_MADD_EN is
// defined), runs each on a fixed-latency down-counter and commits the result
// to HI/LO. mthi/mtlo write HI/LO directly. busy feeds the D-stage stall unit.
//
// Optional feature macro: MD_MADD_EN (enables op 7 madd and op 8 maddu).
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   op     in   [3:0] operation code (0 none,1 mult,2 multu,3 div,4 divu,
//                5 mthi,6 mtlo,7 madd,8 maddu, others none)
//   req    in   flush this cycle; blocks acceptance of op
//   a      in   [31:0] rs operand
//   b      in   [31:0] rt operand
//   rd_hi  in   1 selects HI, 0 selects LO on rdata
//   busy   out  HI/LO busy to the stall unit
//   rdata  out  [31:0] selected HI or LO
//   hi     out  [31:0] HI register
//   lo     out  [31:0] LO register
module md_hilo_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op,
  input  logic        req,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rd_hi,
  output logic        busy,
  output logic [31:0] rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;

  // Operation class latched at acceptance
  localparam logic [1:0] KIND_MUL  = 2'd0;
  localparam logic [1:0] KIND_DIV  = 2'd1;
  localparam logic [1:0] KIND_MADD = 2'd2;

  localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  kind_q, kind_d;
  logic        sgn_q, sgn_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;

  logic        idle;
  logic        is_mul, is_div, is_madd, is_signed;
  logic        accept;

  assign idle = (cnt_q == 4'd0);

  // Opcode decode
  always_comb begin
    is_mul    = (op == OP_MULT) || (op == OP_MULTU);
    is_div    = (op == OP_DIV)  || (op == OP_DIVU);
    is_madd   = 1'b0;
    is_signed = (op == OP_MULT) || (op == OP_DIV);
`ifdef MD_MADD_EN
    is_madd   = (op == OP_MADD) || (op == OP_MADDU);
    is_signed = is_signed || (op == OP_MADD);
`else
    // madd/maddu decode to "none" in this build
    if ((op == OP_MADD) || (op == OP_MADDU)) begin
      is_madd = 1'b0;
    end
`endif
  end

  assign accept = (is_mul || is_div || is_madd) && !req && idle;
  assign busy   = accept || !idle;

  // Datapath on the latched operands. Sign extension to 64 bits lets one
  // unsigned multiplier serve both signed and unsigned products.
  logic [63:0] a_ext, b_ext, prod;
  assign a_ext = {{32{sgn_q & a_q[31]}}, a_q};
  assign b_ext = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod  = a_ext * b_ext;

  // Signed division via magnitudes: avoids the -2^31 / -1 overflow corner,
  // which naturally yields quotient 0x80000000, remainder 0.
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
  assign a_neg = sgn_q & a_q[31];
  assign b_neg = sgn_q & b_q[31];
  assign a_mag = a_neg ? (32'd0 - a_q) : a_q;
  assign b_mag = b_neg ? (32'd0 - b_q) : b_q;
  assign q_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
  assign r_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
  assign quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem   = a_neg ? (32'd0 - r_mag) : r_mag;

  logic [63:0] result;
  always_comb begin
    result = prod;
    case (kind_q)
      KIND_DIV: begin
        if (b_q == 32'd0) result = {a_q, 32'hFFFF_FFFF};
        else              result = {rem, quot};
      end
      KIND_MADD: result = {hi_q, lo_q} + prod;
      default:   result = prod;
    endcase
  end

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    cnt_d  = cnt_q;
    kind_d = kind_q;
    sgn_d  = sgn_q;
    a_d    = a_q;
    b_d    = b_q;
    if (accept) begin
      a_d    = a;
      b_d    = b;
      sgn_d  = is_signed;
      kind_d = is_div ? KIND_DIV : (is_madd ? KIND_MADD : KIND_MUL);
      cnt_d  = is_div ? DIV_LAT : MULT_LAT;
    end else if (cnt_q == 4'd1) begin
      {hi_d, lo_d} = result;
      cnt_d        = 4'd0;
    end else if (!idle) begin
      cnt_d = cnt_q - 4'd1;
    end else if (!req && (op == OP_MTHI)) begin
      hi_d = a;
    end else if (!req && (op == OP_MTLO)) begin
      lo_d = a;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      cnt_q  <= 4'd0;
      kind_q <= KIND_MUL;
      sgn_q  <= 1'b0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      cnt_q  <= cnt_d;
      kind_q <= kind_d;
      sgn_q  <= sgn_d;
      a_q    <= a_d;
      b_q    <= b_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign rdata = rd_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_md_hilo_unit.sv
// tb/tb_md_hilo_unit.sv - directed scoreboard bench for md_hilo_unit
module tb_md_hilo_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  op;
  logic        req;
  logic [31:0] a, b;
  logic        rd_hi;
  logic        busy;
  logic [31:0] rdata, hi, lo;

  int vectors = 0;
  int errors  = 0;

  logic [63:0] sb_q[$];
  logic [31:0] m_hi, m_lo;

  md_hilo_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .op    (op),
    .req   (req),
    .a     (a),
    .b     (b),
    .rd_hi (rd_hi),
    .busy  (busy),
    .rdata (rdata),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_hi"}, hi, m_hi);
    chk({tag, "_lo"}, lo, m_lo);
    rd_hi = 1'b1; #1;
    chk({tag, "_rdata_hi"}, rdata, m_hi);
    rd_hi = 1'b0; #1;
    chk({tag, "_rdata_lo"}, rdata, m_lo);
  endtask

  // Issue one mult/div-class op and follow it to commit
  task automatic run_md(input string tag, input logic [3:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int n, input logic [63:0] exp);
    logic [63:0] e;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    op = o; a = x; b = y;
    #1 chk({tag, "_busy_issue"}, 32'(busy), 32'd1);
    @(posedge clk); #1;
    op = 4'd0;
    chk({tag, "_busy_c1"}, 32'(busy), 32'd1);
    chk({tag, "_hi_held"}, hi, m_hi);
    chk({tag, "_lo_held"}, lo, m_lo);
    for (int k = 2; k <= n; k++) begin
      @(posedge clk); #1;
      chk({tag, "_busy_run"}, 32'(busy), 32'd1);
    end
    @(posedge clk); #1;
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    if (sb_q.size() == 0) begin
      vectors++; errors++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end else begin
      e = sb_q.pop_front();
      m_hi = e[63:32];
      m_lo = e[31:0];
      chk_state(tag);
    end
  endtask

  task automatic move_to(input string tag, input logic [3:0] o, input logic [31:0] x);
    @(posedge clk); #1;
    op = o; a = x;
    #1 chk({tag, "_busy"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    op = 4'd0;
    if (o == 4'd5) m_hi = x; else m_lo = x;
    chk_state(tag);
  endtask

  initial begin
    reset = 1'b0; op = 4'd0; req = 1'b0; a = 32'd0; b = 32'd0; rd_hi = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk_state("rst");
    reset = 1'b1;

    run_md("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 5, 64'hFFFF_FFFF_FFFF_FFFA);
    run_md("divu", 4'd4, 32'd100, 32'd7, 10, {32'd2, 32'd14});
    run_md("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 10, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_md("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, {32'd0, 32'h8000_0000});
    run_md("divu_z", 4'd4, 32'h0000_1234, 32'd0, 10, {32'h0000_1234, 32'hFFFF_FFFF});
    run_md("multu", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 64'hFFFF_FFFF * 64'hFFFF_FFFF);
    run_md("div_z", 4'd3, 32'hFFFF_FF00, 32'd0, 10, {32'hFFFF_FF00, 32'hFFFF_FFFF});

    move_to("mthi", 4'd5, 32'hDEAD_BEEF);
    move_to("mtlo", 4'd6, 32'h0BAD_F00D);

    // Flushed op has no effect
    @(posedge clk); #1;
    op = 4'd2; req = 1'b1; a = 32'd5; b = 32'd7;
    #1 chk("req_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    op = 4'd0; req = 1'b0;
    chk("req_busy_after", 32'(busy), 32'd0);
    chk_state("req");

    // Reset mid-operation abandons the op
    @(posedge clk); #1;
    op = 4'd2; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    op = 4'd0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    m_hi = 32'd0; m_lo = 32'd0;
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk_state("rstmid");
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("rstmid_busy_late", 32'(busy), 32'd0);
    chk_state("rstmid_late");

    move_to("mtlo_ones", 4'd6, 32'hFFFF_FFFF);
`ifdef MD_MADD_EN
    run_md("maddu", 4'd8, 32'd1, 32'd1, 5, {32'd1, 32'd0});
    run_md("madd", 4'd7, 32'hFFFF_FFFF, 32'd2, 5, {32'd0, 32'hFFFF_FFFE});
`else
    @(posedge clk); #1;
    op = 4'd8; a = 32'd1; b = 32'd1;
    #1 chk("maddu_off_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    op = 4'd0;
    chk("maddu_off_busy_after", 32'(busy), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk_state("maddu_off");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
